// File: rtl/serial_word_packer_if.sv
// Stream bundle for serial_word_packer: serial bit input side and
// assembled-word output side, plus the partial-word fill count.
interface serial_word_packer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned FILL_W = $clog2(DATA_WIDTH) + 1;

    logic                  din;
    logic                  din_valid;
    logic                  din_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [FILL_W-1:0]     fill;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, fill
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, fill
    );
endinterface

// File: rtl/serial_word_packer.sv
// Deserializer: collects serial bits LSB-first into DATA_WIDTH-bit words and
// hands them out through a one-word holding register on a valid/ready port.
module serial_word_packer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input logic              clk,
    input logic              reset,
    serial_word_packer_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(DATA_WIDTH) + 1;

    logic [DATA_WIDTH-2:0] partial_q;
    logic [DATA_WIDTH-1:0] shifted;
    logic [FILL_W-1:0]     fill_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  last_bit;
    logic                  din_ready_c;
    logic                  accept;
    logic                  consume;

    always_comb begin
        last_bit    = (fill_q == FILL_W'(DATA_WIDTH - 1));
        // Only the final bit of a word can stall, and only if the held word
        // is not leaving this same cycle (combinational from dout_ready).
        din_ready_c = !(last_bit && dout_valid_q && !bus.dout_ready);
        accept      = bus.din_valid && din_ready_c;
        consume     = dout_valid_q && bus.dout_ready;
        // New bits enter at the top and walk down; after DATA_WIDTH-1 shifts
        // the first accepted bit sits at bit 0.
        shifted     = {bus.din, partial_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            partial_q    <= '0;
            fill_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                partial_q <= shifted[DATA_WIDTH-1:1];
                if (last_bit) begin
                    fill_q <= '0;
                end else begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end

            // A completion may coincide with a consume; the load wins and
            // dout_valid stays high with no bubble.
            if (accept && last_bit) begin
                dout_q       <= shifted;
                dout_valid_q <= 1'b1;
            end else if (consume) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign bus.din_ready  = din_ready_c;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.fill       = fill_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// Directed self-checking bench for serial_word_packer (DATA_WIDTH = 16).
module tb_serial_word_packer;
    localparam int unsigned DW = 16;

    logic clk;
    logic reset;

    serial_word_packer_if #(.DATA_WIDTH(DW)) bus();

    serial_word_packer #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one bit for exactly one rising edge, then drop din_valid.
    task automatic put_bit(input logic b);
        bus.din       = b;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.din_valid = 1'b0;
        bus.din       = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] w;
    int unsigned pulses;
    int unsigned first_pos;
    int unsigned second_pos;
    int unsigned stalls;
    logic [15:0] first_word;
    logic [15:0] second_word;
    logic [4:0]  fill_before;

    initial begin
        reset          = 1'b1;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // 1: reset values, then asynchronous reset mid-cycle
        check("rst_dout",       32'(bus.dout),       32'h0);
        check("rst_dout_valid", 32'(bus.dout_valid), 32'h0);
        check("rst_fill",       32'(bus.fill),       32'h0);
        check("rst_din_ready",  32'(bus.din_ready),  32'h1);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        check("pre_async_fill", 32'(bus.fill), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_fill",       32'(bus.fill),       32'h0);
        check("async_dout_valid", 32'(bus.dout_valid), 32'h0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("async_din_ready", 32'(bus.din_ready), 32'h1);

        // 2: single word
        w = 16'hA5C3;
        bus.dout_ready = 1'b1;
        for (int unsigned i = 0; i < DW; i++) begin
            put_bit(w[i]);
            if (i < DW - 1) check("single_valid_low", 32'(bus.dout_valid), 32'h0);
        end
        check("single_valid", 32'(bus.dout_valid), 32'h1);
        check("single_dout",  32'(bus.dout),       32'hA5C3);
        check("single_fill",  32'(bus.fill),       32'h0);
        idle_cycle();
        check("single_pulse_1cyc", 32'(bus.dout_valid), 32'h0);
        check("single_dout_kept",  32'(bus.dout),       32'hA5C3);

        // 3: back-to-back words, no stalls
        pulses = 0; first_pos = 0; second_pos = 0; stalls = 0;
        first_word = '0; second_word = '0;
        for (int unsigned i = 0; i < 2 * DW; i++) begin
            w = (i < DW) ? 16'hFFFF : 16'h0001;
            bus.din       = w[i % DW];
            bus.din_valid = 1'b1;
            #1;
            if (!bus.din_ready) stalls++;
            @(posedge clk);
            #1;
            if (bus.dout_valid) begin
                pulses++;
                if (pulses == 1) begin first_pos = i; first_word = bus.dout; end
                else begin second_pos = i; second_word = bus.dout; end
            end
        end
        bus.din_valid = 1'b0;
        check("b2b_pulses",  32'(pulses),      32'd2);
        check("b2b_first",   32'(first_word),  32'hFFFF);
        check("b2b_second",  32'(second_word), 32'h0001);
        check("b2b_spacing", 32'(second_pos - first_pos), 32'd16);
        check("b2b_stalls",  32'(stalls),      32'd0);
        idle_cycle();
        check("b2b_valid_drop", 32'(bus.dout_valid), 32'h0);

        // 4: backpressure on the final bit
        bus.dout_ready = 1'b0;
        w = 16'h1234;
        for (int unsigned i = 0; i < DW; i++) put_bit(w[i]);
        check("bp_held_valid", 32'(bus.dout_valid), 32'h1);
        check("bp_held_dout",  32'(bus.dout),       32'h1234);
        w = 16'h8000;
        for (int unsigned i = 0; i < DW - 1; i++) put_bit(w[i]);
        check("bp_fill15", 32'(bus.fill), 32'd15);
        bus.din       = 1'b1;
        bus.din_valid = 1'b1;
        #1;
        check("bp_din_ready_low", 32'(bus.din_ready), 32'h0);
        @(posedge clk);
        #1;
        check("bp_fill_stall", 32'(bus.fill), 32'd15);
        check("bp_dout_stable", 32'(bus.dout), 32'h1234);
        bus.dout_ready = 1'b1;
        #1;
        check("bp_din_ready_comb", 32'(bus.din_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        check("bp_new_dout",  32'(bus.dout),       32'h8000);
        check("bp_new_valid", 32'(bus.dout_valid), 32'h1);
        check("bp_new_fill",  32'(bus.fill),       32'h0);
        idle_cycle();
        check("bp_consumed", 32'(bus.dout_valid), 32'h0);

        // 5: gaps between bits are transparent
        w = 16'h5A5A;
        for (int unsigned i = 0; i < DW; i++) begin
            fill_before = bus.fill;
            for (int unsigned g = 0; g < (i % 3); g++) begin
                bus.din = ~w[i];
                idle_cycle();
            end
            check("gap_fill_hold", 32'(bus.fill), 32'(fill_before));
            put_bit(w[i]);
            if (i < DW - 1) check("gap_fill_inc", 32'(bus.fill), 32'(i + 1));
        end
        check("gap_dout",  32'(bus.dout),       32'h5A5A);
        check("gap_valid", 32'(bus.dout_valid), 32'h1);
        idle_cycle();

        // 6: reset mid-word with a held word
        bus.dout_ready = 1'b0;
        w = 16'h00FF;
        for (int unsigned i = 0; i < DW; i++) put_bit(w[i]);
        check("mid_held_dout", 32'(bus.dout), 32'h00FF);
        for (int unsigned i = 0; i < 7; i++) put_bit(1'b1);
        check("mid_fill7", 32'(bus.fill), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("mid_valid_clr", 32'(bus.dout_valid), 32'h0);
        check("mid_fill_clr",  32'(bus.fill),       32'h0);
        check("mid_dout_clr",  32'(bus.dout),       32'h0);
        #1;
        reset = 1'b0;
        bus.dout_ready = 1'b1;
        @(posedge clk);
        #1;
        w = 16'hC001;
        for (int unsigned i = 0; i < DW; i++) put_bit(w[i]);
        check("mid_next_dout",  32'(bus.dout),       32'hC001);
        check("mid_next_valid", 32'(bus.dout_valid), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
